wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, sets the number of denied cycles after which a buffered MDU write forces a pipeline stall (range 1..15).
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, with ports named as follows.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-low reset; rst=0 sampled at posedge resets the block.
REQ-005 wb_wreg  in  1  pipeline writeback write enable.
REQ-006 wb_destR  in  5  pipeline writeback register address.
REQ-007 wb_dest  in  32  pipeline writeback data.
REQ-008 mdu_valid  in  1  multi-cycle unit result valid.
REQ-009 mdu_destR  in  5  MDU destination register.
REQ-010 mdu_data  in  32  MDU result.
REQ-011 mdu_ready  out  1  MDU result accepted when mdu_valid and mdu_ready are both 1 at posedge.
REQ-012 rf_we, rf_waddr[4:0], rf_wdata[31:0]  out  register-file write port, all registered.
REQ-013 pend_valid, pend_destR[4:0]  out  buffered MDU write pending, for the hazard unit.
REQ-014 wb_stall  out  1  freezes the MEM/WB register and all upstream stages.

Function
REQ-015 The block SHALL hold a one-entry buffer (buf_valid, buf_destR, buf_data) and a 4-bit saturating age counter.
REQ-016 mdu_ready SHALL equal ~buf_valid (combinational).
REQ-017 Grant per cycle, in priority order:
 - wb_stall=1 grants the buffer.
 - otherwise wb_wreg=1 grants WB.
 - otherwise buf_valid=1 grants the buffer.
 - otherwise an accepted MDU handshake grants the MDU directly.
 - otherwise no grant.
REQ-018 The granted source SHALL appear on rf_we/rf_waddr/rf_wdata at the next posedge (1-cycle latency); with no grant, rf_we=0 and addr/data hold their values.
REQ-019 A grant with destination 0 SHALL produce rf_we=0 but still consume the request (buffer cleared or handshake completed).
REQ-020 An accepted MDU result not granted in its acceptance cycle SHALL be captured into the buffer with age=0.
REQ-021 Each cycle the buffer is valid and not granted, age SHALL increment, saturating at 15; a buffer grant clears buf_valid and age.
REQ-022 pend_valid SHALL equal buf_valid; pend_destR SHALL equal buf_destR (0 when the buffer is empty).
REQ-023 While wb_stall=1 the WB request is not written; the pipeline SHALL present the same WB write next cycle (guaranteed by freeze), so no WB write is lost.
REQ-024 Buffer full: mdu_ready=0. The MDU SHALL hold mdu_valid and its data; holding is the MDU's responsibility.
REQ-025 Buffer grant and new MDU acceptance SHALL NOT occur in the same cycle, because mdu_ready=0 while the buffer is full.

Reset
REQ-026 On rst=0 at posedge, the block SHALL set rf_we=0, rf_waddr=0, rf_wdata=0, buf_valid=0, buf_destR=0, buf_data=0 and age=0.
REQ-027 During a reset cycle, wb_wreg and mdu_valid SHALL be ignored; a buffered entry is discarded.
REQ-028 After reset, mdu_ready=1, wb_stall=0 and pend_valid=0.

Configuration
REQ-029 Macro WB_ARB_STARVE_EN defined: wb_stall = buf_valid && (age >= STARVE_LIMIT), combinational.
REQ-030 Macro WB_ARB_STARVE_EN undefined: wb_stall is tied to 0, the age counter is omitted, and the buffer waits for a cycle with wb_wreg=0.

Verification
REQ-031 Reset, then MDU-only write: mdu_valid=1, mdu_destR=5, mdu_data=0xDEADBEEF, wb_wreg=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; pend_valid stays 0.
REQ-032 Collision: wb_wreg=1, destR=3, data=0x11 and the MDU handshake (destR=7, data=0x22) in the same cycle -> next cycle writes r3=0x11 with pend_valid=1, pend_destR=7, mdu_ready=0; the first cycle with wb_wreg=0 then writes r7=0x22 and pend_valid drops.
REQ-033 Starvation (macro defined, STARVE_LIMIT=4): buffer full and wb_wreg held 1 -> wb_stall=1 when age reaches 4; the next edge writes the buffer entry; the following edge writes the held WB entry; wb_stall=0 afterwards.
REQ-034 Starvation with the macro undefined: buffer full and wb_wreg=1 for 20 cycles -> wb_stall stays 0 and pend_valid stays 1; the buffer drains on the first wb_wreg=0 cycle.
REQ-035 Zero register: WB destR=0, then MDU destR=0 -> rf_we stays 0 in both cases; the MDU handshake completes and no pending entry remains.
REQ-036 Reset mid-operation: buffer full (destR=9), rst=0 for one cycle -> rf_we=0, pend_valid=0 and mdu_ready=1 after reset; r9 is never written.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: shares one RF write port between pipeline writeback and a
// multi-cycle unit, with a one-entry MDU buffer. Define WB_ARB_STARVE_EN to enable the starvation stall.
module wb_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_wreg,
   input  logic [4:0]  wb_destR,
   input  logic [31:0] wb_dest,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_destR,
   input  logic [31:0] mdu_data,
   output logic        mdu_ready,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        pend_valid,
   output logic [4:0]  pend_destR,
   output logic        wb_stall
);

   typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_BUF, GNT_MDU} gnt_e;

   logic        buf_valid;
   logic [4:0]  buf_destR;
   logic [31:0] buf_data;
   logic        mdu_acc;
   logic        buf_capture;
   gnt_e        gnt;
   logic [4:0]  gnt_addr;
   logic [31:0] gnt_data;

   // Out-of-range limits leave an empty marker scope that is visible in the elaborated hierarchy.
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_out_of_range
   end

   assign mdu_ready   = ~buf_valid;
   assign mdu_acc     = mdu_valid & ~buf_valid;
   assign pend_valid  = buf_valid;
   assign pend_destR  = buf_valid ? buf_destR : 5'd0;
   assign buf_capture = mdu_acc && (gnt != GNT_MDU);

`ifdef WB_ARB_STARVE_EN
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

   logic [3:0] age;

   assign wb_stall = buf_valid && (age >= STARVE_LIM);

   always_ff @(posedge clk) begin
      if (!rst) begin
         age <= 4'd0;
      end else if (gnt == GNT_BUF || buf_capture) begin
         age <= 4'd0;
      end else if (buf_valid && age != 4'd15) begin
         age <= age + 4'd1;
      end
   end
`else
   assign wb_stall = 1'b0;
`endif

   // A stall only occurs with the buffer full, so its branch always grants a valid entry.
   always_comb begin
      gnt      = GNT_NONE;
      gnt_addr = buf_destR;
      gnt_data = buf_data;
      if (wb_stall)       gnt = GNT_BUF;
      else if (wb_wreg)   gnt = GNT_WB;
      else if (buf_valid) gnt = GNT_BUF;
      else if (mdu_acc)   gnt = GNT_MDU;
      case (gnt)
         GNT_WB: begin
            gnt_addr = wb_destR;
            gnt_data = wb_dest;
         end
         GNT_MDU: begin
            gnt_addr = mdu_destR;
            gnt_data = mdu_data;
         end
         default: begin
            gnt_addr = buf_destR;
            gnt_data = buf_data;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rf_we     <= 1'b0;
         rf_waddr  <= 5'd0;
         rf_wdata  <= 32'd0;
         buf_valid <= 1'b0;
         buf_destR <= 5'd0;
         buf_data  <= 32'd0;
      end else begin
         // r0 is hardwired: the request is consumed but the RF write is suppressed.
         rf_we <= (gnt != GNT_NONE) && (gnt_addr != 5'd0);
         if (gnt != GNT_NONE) begin
            rf_waddr <= gnt_addr;
            rf_wdata <= gnt_data;
         end
         if (gnt == GNT_BUF) begin
            buf_valid <= 1'b0;
            buf_destR <= 5'd0;
            buf_data  <= 32'd0;
         end else if (buf_capture) begin
            buf_valid <= 1'b1;
            buf_destR <= mdu_destR;
            buf_data  <= mdu_data;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, MDU-only, collision, starvation, r0 and mid-op reset.
module tb_wb_port_arbiter;

   logic        clk;
   logic        rst;
   logic        wb_wreg;
   logic [4:0]  wb_destR;
   logic [31:0] wb_dest;
   logic        mdu_valid;
   logic [4:0]  mdu_destR;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        pend_valid;
   logic [4:0]  pend_destR;
   logic        wb_stall;

   int checks = 0;
   int errors = 0;

   wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .wb_wreg(wb_wreg), .wb_destR(wb_destR), .wb_dest(wb_dest),
      .mdu_valid(mdu_valid), .mdu_destR(mdu_destR), .mdu_data(mdu_data),
      .mdu_ready(mdu_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pend_valid(pend_valid), .pend_destR(pend_destR), .wb_stall(wb_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_wreg = 0; wb_destR = 0; wb_dest = 0;
      mdu_valid = 0; mdu_destR = 0; mdu_data = 0;
   endtask

   initial begin
      rst = 0;
      idle_inputs();
      step();
      step();
      rst = 1;
      chk("rst_rf_we", 32'(rf_we), 0);
      chk("rst_rf_waddr", 32'(rf_waddr), 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_mdu_ready", 32'(mdu_ready), 1);
      chk("rst_wb_stall", 32'(wb_stall), 0);
      chk("rst_pend_valid", 32'(pend_valid), 0);
      chk("rst_pend_destR", 32'(pend_destR), 0);

      // MDU-only write goes straight to the RF
      mdu_valid = 1; mdu_destR = 5; mdu_data = 32'hDEADBEEF;
      chk("mdu_only_ready", 32'(mdu_ready), 1);
      step();
      idle_inputs();
      chk("mdu_only_we", 32'(rf_we), 1);
      chk("mdu_only_addr", 32'(rf_waddr), 5);
      chk("mdu_only_data", rf_wdata, 32'hDEADBEEF);
      chk("mdu_only_pend", 32'(pend_valid), 0);
      step();
      chk("idle_we", 32'(rf_we), 0);
      chk("idle_addr_hold", 32'(rf_waddr), 5);
      chk("idle_data_hold", rf_wdata, 32'hDEADBEEF);

      // Collision: WB wins, MDU result buffered
      wb_wreg = 1; wb_destR = 3; wb_dest = 32'h11;
      mdu_valid = 1; mdu_destR = 7; mdu_data = 32'h22;
      step();
      idle_inputs();
      chk("coll_we", 32'(rf_we), 1);
      chk("coll_addr", 32'(rf_waddr), 3);
      chk("coll_data", rf_wdata, 32'h11);
      chk("coll_pend", 32'(pend_valid), 1);
      chk("coll_pend_destR", 32'(pend_destR), 7);
      chk("coll_mdu_ready", 32'(mdu_ready), 0);
      step();
      chk("drain_we", 32'(rf_we), 1);
      chk("drain_addr", 32'(rf_waddr), 7);
      chk("drain_data", rf_wdata, 32'h22);
      chk("drain_pend", 32'(pend_valid), 0);
      chk("drain_mdu_ready", 32'(mdu_ready), 1);

      // Starvation: buffer r8, WB keeps writing r10
      wb_wreg = 1; wb_destR = 4; wb_dest = 32'h44;
      mdu_valid = 1; mdu_destR = 8; mdu_data = 32'h88;
      step();
      mdu_valid = 0; mdu_destR = 0; mdu_data = 0;
      wb_destR = 10; wb_dest = 32'hAA;
      chk("starve_first_addr", 32'(rf_waddr), 4);
      chk("starve_pend", 32'(pend_valid), 1);
      chk("starve_stall0", 32'(wb_stall), 0);
`ifdef WB_ARB_STARVE_EN
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("starve_wb_addr", 32'(rf_waddr), 10);
         chk("starve_stall", 32'(wb_stall), (i >= 4) ? 32'd1 : 32'd0);
      end
      step();
      chk("starve_buf_we", 32'(rf_we), 1);
      chk("starve_buf_addr", 32'(rf_waddr), 8);
      chk("starve_buf_data", rf_wdata, 32'h88);
      chk("starve_pend_clr", 32'(pend_valid), 0);
      chk("starve_stall_clr", 32'(wb_stall), 0);
      step();
      chk("starve_held_wb_addr", 32'(rf_waddr), 10);
      chk("starve_held_wb_data", rf_wdata, 32'hAA);
      chk("starve_after_stall", 32'(wb_stall), 0);
      idle_inputs();
      step();
`else
      for (int i = 0; i < 20; i++) begin
         step();
         chk("nostarve_stall", 32'(wb_stall), 0);
         chk("nostarve_pend", 32'(pend_valid), 1);
         chk("nostarve_wb_addr", 32'(rf_waddr), 10);
      end
      idle_inputs();
      step();
      chk("nostarve_drain_we", 32'(rf_we), 1);
      chk("nostarve_drain_addr", 32'(rf_waddr), 8);
      chk("nostarve_drain_data", rf_wdata, 32'h88);
      chk("nostarve_pend_clr", 32'(pend_valid), 0);
`endif
      step();
      chk("starve_idle_we", 32'(rf_we), 0);

      // r0 writes are consumed but never hit the RF
      wb_wreg = 1; wb_destR = 0; wb_dest = 32'h55;
      step();
      idle_inputs();
      chk("zero_wb_we", 32'(rf_we), 0);
      mdu_valid = 1; mdu_destR = 0; mdu_data = 32'h66;
      chk("zero_mdu_ready", 32'(mdu_ready), 1);
      step();
      idle_inputs();
      chk("zero_mdu_we", 32'(rf_we), 0);
      chk("zero_mdu_pend", 32'(pend_valid), 0);
      chk("zero_mdu_ready_after", 32'(mdu_ready), 1);

      // Reset with r9 buffered; requests during reset are ignored
      wb_wreg = 1; wb_destR = 1; wb_dest = 32'h01;
      mdu_valid = 1; mdu_destR = 9; mdu_data = 32'h99;
      step();
      chk("rstmid_pend", 32'(pend_valid), 1);
      chk("rstmid_pend_destR", 32'(pend_destR), 9);
      rst = 0;
      wb_wreg = 1; wb_destR = 2; wb_dest = 32'h22;
      mdu_valid = 1; mdu_destR = 12; mdu_data = 32'hCC;
      step();
      idle_inputs();
      rst = 1;
      chk("rstmid_we", 32'(rf_we), 0);
      chk("rstmid_addr", 32'(rf_waddr), 0);
      chk("rstmid_pend_clr", 32'(pend_valid), 0);
      chk("rstmid_mdu_ready", 32'(mdu_ready), 1);
      chk("rstmid_stall", 32'(wb_stall), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rstmid_no_r9_we", 32'(rf_we), 0);
         chk("rstmid_no_r9_pend", 32'(pend_valid), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
